// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM arbiter: widths, requester count, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package sp_ram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 48;
    localparam int N_REQ      = 2;

    // Legal read latencies, matching the two output-register modes of the wrapper.
    localparam int RD_LAT_LL = 1;   // LOW_LATENCY: no output register
    localparam int RD_LAT_HP = 2;   // HIGH_PERFORMANCE: regceb-gated output register

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic bit rd_latency_ok(int lat);
        return (lat == RD_LAT_LL) || (lat == RD_LAT_HP);
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two packed request lanes plus grant/response.
// Latency: n/a (wires only).
// Backpressure: req_i is held by the requester until its gnt_o bit is seen.
// Ports: master = requester side, slave = arbiter side.
interface sp_ram_arbiter_if
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        we_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*DATA_W-1:0] wdata_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]       rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/ihp_single_port_256x48.sv
// Behavioural model of the 256x48 SRAM wrapper: write port A, read port B.
// Latency: 1 cycle (LOW_LATENCY) or 2 cycles with regceb-gated output register (HIGH_PERFORMANCE).
// Backpressure: none; one access per clock.
// Ports: clk, ena/wea/addra/dina (write), enb/regceb/addrb/doutb (read).
module ihp_single_port_256x48 #(
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic        clk,
    input  logic        ena,
    input  logic        wea,
    input  logic [7:0]  addra,
    input  logic [47:0] dina,
    input  logic        enb,
    input  logic        regceb,
    input  logic [7:0]  addrb,
    output logic [47:0] doutb
);

    logic [47:0] mem [256];
    logic [47:0] ram_data;

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
        if (enb) begin
            ram_data <= mem[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_ll
        assign doutb = ram_data;
    end else begin : g_hp
        logic [47:0] dout_q;
        always_ff @(posedge clk) begin
            if (regceb) begin
                dout_q <= ram_data;
            end
        end
        assign doutb = dout_q;
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
// Latency: purely combinational; the last-grant pointer is held by the parent.
// Backpressure: none here; a losing request stays asserted and wins the next tie.
// Ports: req (request vector), lp (last granted ID), gnt (one-hot grant, 0 when idle).
module rr_arb2
    import sp_ram_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             lp,
    output logic [N_REQ-1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = lp ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port 256x48 SRAM wrapper between two requesters, with a clear sweep.
// Latency: grant and RAM access same cycle; read data RD_LATENCY cycles after the grant.
// Backpressure: requests are held until granted; no grants while the clear sweep runs.
// Ports: clk/rst, clr_start/busy, bus (requester interface), ram_* (wrapper pins).
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int RD_LATENCY     = RD_LAT_HP,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              busy,
    sp_ram_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic              ram_enb,
    output logic              ram_regceb,
    input  logic [DATA_W-1:0] ram_doutb
);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("sp_ram_arbiter: RD_LATENCY must be 1 or 2");
    end

    state_t                  st_q, st_d;
    logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                    lp_q, lp_d;
    logic [RD_LATENCY-1:0]   tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0]   tag_id_q, tag_id_d;

    logic [N_REQ-1:0]        arb_gnt;
    logic [N_REQ-1:0]        gnt;
    logic                    sel_id;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    last_vld;
    logic                    last_id;

    rr_arb2 u_arb (
        .req (bus.req_i),
        .lp  (lp_q),
        .gnt (arb_gnt)
    );

    // With a one-hot (or zero) grant, bit 1 alone identifies the winner.
    assign sel_id    = arb_gnt[1];
    assign sel_we    = bus.we_i[sel_id];
    assign sel_addr  = sel_id ? bus.addr_i[2*ADDR_W-1:ADDR_W] : bus.addr_i[ADDR_W-1:0];
    assign sel_wdata = sel_id ? bus.wdata_i[2*DATA_W-1:DATA_W] : bus.wdata_i[DATA_W-1:0];

    always_comb begin
        st_d      = st_q;
        clr_cnt_d = clr_cnt_q;
        lp_d      = lp_q;
        gnt       = '0;
        ram_ena   = 1'b0;
        ram_wea   = 1'b0;
        ram_enb   = 1'b0;
        ram_addra = sel_addr;
        ram_addrb = sel_addr;
        ram_dina  = sel_wdata;

        case (st_q)
            ST_CLEAR: begin
                ram_ena   = 1'b1;
                ram_wea   = 1'b1;
                ram_addra = clr_cnt_q;
                ram_dina  = '0;
                // Counter wraps back to 0 on the last word, ready for the next sweep.
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    st_d = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt = arb_gnt;
                if (|arb_gnt) begin
                    lp_d = sel_id;
                    // ena is the wrapper's write strobe, so a read must only raise enb.
                    if (sel_we) begin
                        ram_ena = 1'b1;
                        ram_wea = 1'b1;
                    end else begin
                        ram_enb = 1'b1;
                    end
                end
                // The request seen alongside clr_start is still served this cycle.
                if (clr_start) begin
                    st_d      = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: st_d = ST_RUN;
        endcase

        if (rst) begin
            gnt     = '0;
            ram_ena = 1'b0;
            ram_wea = 1'b0;
            ram_enb = 1'b0;
        end

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = ram_enb;
        tag_id_d[0]  = sel_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) begin
                st_q <= ST_CLEAR;
            end else begin
                st_q <= ST_RUN;
            end
            clr_cnt_q <= '0;
            lp_q      <= 1'b1;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            st_q      <= st_d;
            clr_cnt_q <= clr_cnt_d;
            lp_q      <= lp_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign last_vld = tag_vld_q[RD_LATENCY-1];
    assign last_id  = tag_id_q[RD_LATENCY-1];

    // In HIGH_PERFORMANCE mode the output register loads one cycle after the array read.
    assign ram_regceb   = !rst && (RD_LATENCY == RD_LAT_HP) && tag_vld_q[0];
    assign busy         = rst ? CLEAR_ON_RESET : (st_q == ST_CLEAR);
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rst ? 2'b00 : {last_vld & last_id, last_vld & ~last_id};
    assign bus.rdata_o  = ram_doutb;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

    localparam logic [47:0] D_A = 48'h123456789ABC;
    localparam logic [47:0] D_B = 48'hDEADBEEF0020;
    localparam logic [47:0] D_C = 48'hCAFEF00D0020;

    logic clk;
    logic rst;
    logic clr_start;
    logic busy;
    logic clr_start_ll;
    logic busy_ll;

    logic [7:0]  m_addra, m_addrb, s_addra, s_addrb;
    logic [47:0] m_dina, m_doutb, s_dina, s_doutb;
    logic        m_ena, m_wea, m_enb, m_regceb;
    logic        s_ena, s_wea, s_enb, s_regceb;

    int n_vec = 0;
    int n_err = 0;
    int ena_on_read = 0;

    sp_ram_arbiter_if #(.ADDR_W(8), .DATA_W(48)) m_if ();
    sp_ram_arbiter_if #(.ADDR_W(8), .DATA_W(48)) s_if ();

    sp_ram_arbiter #(.ADDR_W(8), .DATA_W(48), .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_dut_hp (
        .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy), .bus(m_if),
        .ram_addra(m_addra), .ram_addrb(m_addrb), .ram_dina(m_dina),
        .ram_ena(m_ena), .ram_wea(m_wea), .ram_enb(m_enb), .ram_regceb(m_regceb),
        .ram_doutb(m_doutb)
    );

    ihp_single_port_256x48 #(.RAM_PERFORMANCE("HIGH_PERFORMANCE")) u_ram_hp (
        .clk(clk), .ena(m_ena), .wea(m_wea), .addra(m_addra), .dina(m_dina),
        .enb(m_enb), .regceb(m_regceb), .addrb(m_addrb), .doutb(m_doutb)
    );

    sp_ram_arbiter #(.ADDR_W(8), .DATA_W(48), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b0)) u_dut_ll (
        .clk(clk), .rst(rst), .clr_start(clr_start_ll), .busy(busy_ll), .bus(s_if),
        .ram_addra(s_addra), .ram_addrb(s_addrb), .ram_dina(s_dina),
        .ram_ena(s_ena), .ram_wea(s_wea), .ram_enb(s_enb), .ram_regceb(s_regceb),
        .ram_doutb(s_doutb)
    );

    ihp_single_port_256x48 #(.RAM_PERFORMANCE("LOW_LATENCY")) u_ram_ll (
        .clk(clk), .ena(s_ena), .wea(s_wea), .addra(s_addra), .dina(s_dina),
        .enb(s_enb), .regceb(s_regceb), .addrb(s_addrb), .doutb(s_doutb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A read must never raise the wrapper's write strobe.
    always @(negedge clk) begin
        if (!rst && ((m_ena && m_enb) || (s_ena && s_enb))) begin
            ena_on_read <= ena_on_read + 1;
        end
    end

    typedef struct {
        logic        clr;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [47:0] d0;
        logic [47:0] d1;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [47:0] rd;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic clr, logic [1:0] req, logic [1:0] we, logic [7:0] a0,
                                logic [7:0] a1, logic [47:0] d0, logic [47:0] d1,
                                logic [1:0] gnt, logic [1:0] rv, logic [47:0] rd);
        vec_t v;
        v.clr = clr; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.gnt = gnt; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(logic [1:0] req, logic [1:0] we, logic [7:0] a0, logic [7:0] a1,
                           logic [47:0] d0, logic [47:0] d1);
        m_if.req_i   = req;
        m_if.we_i    = we;
        m_if.addr_i  = {a1, a0};
        m_if.wdata_i = {d1, d0};
    endtask

    task automatic drive_s(logic [1:0] req, logic [1:0] we, logic [7:0] a0, logic [47:0] d0);
        s_if.req_i   = req;
        s_if.we_i    = we;
        s_if.addr_i  = {8'h00, a0};
        s_if.wdata_i = {48'h0, d0};
    endtask

    // Checks clear-sweep cycles first..first+n-1; pulses clr_start at index clr_at to show it is ignored.
    task automatic sweep_check(int first, int n, int clr_at);
        for (int k = 0; k < n; k++) begin
            clr_start = (k == clr_at);
            @(negedge clk);
            chk("sweep busy", first + k, busy, 1);
            chk("sweep gnt", first + k, m_if.gnt_o, 0);
            chk("sweep rvalid", first + k, m_if.rvalid_o, 0);
            chk("sweep addra", first + k, m_addra, first + k);
            chk("sweep ena/wea/enb", first + k, {m_ena, m_wea, m_enb}, 3'b110);
            chk("sweep dina", first + k, m_dina, 0);
            step();
        end
        clr_start = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(0, 2'b10, 2'b00, 8'h00, 8'hFF, 0, 0,   2'b10, 2'b00, 0);
        tbl[1]  = mk(0, 2'b01, 2'b01, 8'h10, 8'h00, D_A, 0, 2'b01, 2'b00, 0);
        tbl[2]  = mk(0, 2'b01, 2'b00, 8'h10, 8'h00, 0, 0,   2'b01, 2'b10, 0);
        tbl[3]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,   2'b00, 2'b00, 0);
        tbl[4]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,   2'b00, 2'b01, D_A);
        tbl[5]  = mk(0, 2'b10, 2'b10, 8'h00, 8'h20, 0, D_B, 2'b10, 2'b00, 0);
        tbl[6]  = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0,   2'b01, 2'b00, 0);
        tbl[7]  = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0,   2'b10, 2'b00, 0);
        tbl[8]  = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0,   2'b01, 2'b01, D_A);
        tbl[9]  = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0,   2'b10, 2'b10, D_B);
        tbl[10] = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0,   2'b01, 2'b01, D_A);
        tbl[11] = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0,   2'b10, 2'b10, D_B);
        tbl[12] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,   2'b00, 2'b01, D_A);
        tbl[13] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,   2'b00, 2'b10, D_B);
        tbl[14] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,   2'b00, 2'b00, 0);
        tbl[15] = mk(0, 2'b01, 2'b00, 8'h10, 8'h00, 0, 0,   2'b01, 2'b00, 0);
        tbl[16] = mk(1, 2'b10, 2'b00, 8'h00, 8'h20, 0, 0,   2'b10, 2'b00, 0);
        tbl[17] = mk(0, 2'b11, 2'b00, 8'h20, 8'h10, 0, 0,   2'b00, 2'b01, D_A);
        tbl[18] = mk(0, 2'b11, 2'b00, 8'h20, 8'h10, 0, 0,   2'b00, 2'b10, D_B);

        rst = 1'b1;
        clr_start = 1'b0;
        clr_start_ll = 1'b0;
        drive_m(2'b11, 2'b00, 8'h00, 8'h00, 0, 0);
        drive_s(2'b00, 2'b00, 8'h00, 0);

        // Reset state, with both requests raised to show the outputs are gated.
        step();
        @(negedge clk);
        chk("rst gnt", 0, m_if.gnt_o, 0);
        chk("rst rvalid", 0, m_if.rvalid_o, 0);
        chk("rst ena/wea/enb", 0, {m_ena, m_wea, m_enb}, 0);
        chk("rst regceb", 0, m_regceb, 0);
        chk("rst busy hp", 0, busy, 1);
        chk("rst busy ll", 0, busy_ll, 0);
        step();
        step();
        rst = 1'b0;
        drive_m(2'b10, 2'b00, 8'h00, 8'hFF, 0, 0);

        // Power-on clear: 256 cycles busy with requester 1 held off.
        sweep_check(0, 256, -1);

        // Run phase: read-after-clear, write-then-read, contention, clr_start collision.
        for (int i = 0; i < 19; i++) begin
            clr_start = tbl[i].clr;
            drive_m(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            @(negedge clk);
            chk("tbl gnt", i, m_if.gnt_o, tbl[i].gnt);
            chk("tbl rvalid", i, m_if.rvalid_o, tbl[i].rv);
            chk("tbl busy", i, busy, (i >= 17));
            if (tbl[i].rv != 2'b00) chk("tbl rdata", i, m_if.rdata_o, tbl[i].rd);
            step();
        end

        // Rest of the commanded sweep; a second clr_start mid-sweep must not extend it.
        sweep_check(2, 254, 50);

        // First grant after the sweep; lp=1 from the collision grant, so requester 0 first.
        @(negedge clk);
        chk("post-clear busy", 0, busy, 0);
        chk("post-clear gnt", 0, m_if.gnt_o, 2'b01);
        step();
        @(negedge clk);
        chk("post-clear gnt", 1, m_if.gnt_o, 2'b10);
        step();
        drive_m(2'b00, 2'b00, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        chk("cleared 0x20 rvalid", 0, m_if.rvalid_o, 2'b01);
        chk("cleared 0x20 rdata", 0, m_if.rdata_o, 0);
        step();
        @(negedge clk);
        chk("cleared 0x10 rvalid", 0, m_if.rvalid_o, 2'b10);
        chk("cleared 0x10 rdata", 0, m_if.rdata_o, 0);
        step();

        // Reset the cycle after a read grant: its response is discarded and lp returns to 1.
        drive_m(2'b01, 2'b00, 8'h10, 8'h00, 0, 0);
        @(negedge clk);
        chk("mid-read gnt", 0, m_if.gnt_o, 2'b01);
        step();
        rst = 1'b1;
        drive_m(2'b00, 2'b00, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        chk("mid-read rst rvalid", 0, m_if.rvalid_o, 0);
        step();
        rst = 1'b0;
        sweep_check(0, 256, -1);
        drive_m(2'b11, 2'b00, 8'h00, 8'h01, 0, 0);
        @(negedge clk);
        chk("lp after rst", 0, m_if.gnt_o, 2'b01);
        step();

        // Write 0x20, hammer with random reads, then confirm 0x20 is intact.
        drive_m(2'b01, 2'b01, 8'h20, 8'h00, D_C, 0);
        @(negedge clk);
        chk("w20 gnt", 0, m_if.gnt_o, 2'b01);
        step();
        for (int r = 0; r < 1000; r++) begin
            drive_m(2'($urandom_range(1, 3)), 2'b00, 8'($urandom), 8'($urandom),
                    48'($urandom), 48'($urandom));
            step();
        end
        drive_m(2'b00, 2'b00, 8'h00, 8'h00, 0, 0);
        repeat (3) step();
        drive_m(2'b01, 2'b00, 8'h20, 8'h00, 0, 0);
        @(negedge clk);
        chk("r20 gnt", 0, m_if.gnt_o, 2'b01);
        step();
        drive_m(2'b00, 2'b00, 8'h00, 8'h00, 0, 0);
        step();
        @(negedge clk);
        chk("r20 rvalid", 0, m_if.rvalid_o, 2'b01);
        chk("r20 rdata", 0, m_if.rdata_o, D_C);
        chk("ena on read", 0, ena_on_read, 0);

        // RD_LATENCY=1 instance: write then read 0x10, data one cycle after the read grant.
        drive_s(2'b01, 2'b01, 8'h10, D_A);
        @(negedge clk);
        chk("ll busy", 0, busy_ll, 0);
        chk("ll w gnt", 0, s_if.gnt_o, 2'b01);
        step();
        drive_s(2'b01, 2'b00, 8'h10, 0);
        @(negedge clk);
        chk("ll r gnt", 0, s_if.gnt_o, 2'b01);
        chk("ll r enb", 0, {s_ena, s_enb}, 2'b01);
        chk("ll rvalid T", 0, s_if.rvalid_o, 0);
        step();
        drive_s(2'b00, 2'b00, 8'h00, 0);
        @(negedge clk);
        chk("ll rvalid T+1", 0, s_if.rvalid_o, 2'b01);
        chk("ll rdata", 0, s_if.rdata_o, D_A);
        chk("ll regceb", 0, s_regceb, 0);
        step();
        @(negedge clk);
        chk("ll rvalid T+2", 0, s_if.rvalid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
